traffic_sensor: RTL and testbench

- Front-end conditioner for the two-road traffic light controller.
- Takes raw vehicle-detector lines for road A and road B, which are asynchronous and may bounce.
- Produces clean, synchronous traffic-present levels `ta`/`tb` that feed the controller's sensor inputs directly.
- Adds a post-vehicle hold time so green does not drop between closely spaced cars.
- Keeps per-road arrival counts for status readout.

---
 rtl/tlc_pkg.sv | 24 ++
 rtl/traffic_sensor_channel.sv | 76 +++++++
 rtl/traffic_sensor.sv | 51 +++++
 tb/tb_traffic_sensor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller front end: default
// sizing, road encoding and a width helper for the per-channel counters.
package tlc_pkg;

  localparam int unsigned DEB_DEF  = 4;
  localparam int unsigned HOLD_DEF = 8;
  localparam int unsigned CW_DEF   = 8;

  typedef enum logic {
    ROAD_A = 1'b0,
    ROAD_B = 1'b1
  } road_e;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/traffic_sensor_channel.sv
// One detector channel: two-flop synchroniser, debounce, post-vehicle hold,
// arrival strobe and saturating arrival counter.
module sensor_channel
  import tlc_pkg::*;
#(
  parameter int unsigned DEB  = DEB_DEF,
  parameter int unsigned HOLD = HOLD_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic          clk,
  input  logic          r_n,
  input  logic          s,
  input  logic          clr,
  output logic          t,
  output logic          arr,
  output logic [CW-1:0] cnt
);

  localparam int unsigned   DW        = clog2(DEB);
  localparam int unsigned   HW        = clog2(HOLD + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEB - 1);
  localparam logic [HW-1:0] HOLD_LD   = HW'(HOLD);

  logic          s_meta;
  logic          s_sync;
  logic          deb;
  logic          deb_nxt;
  logic          deb_q;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nxt;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_nxt;

  always_comb begin
    deb_nxt  = deb;
    dcnt_nxt = '0;
    if (s_sync != deb) begin
      if (dcnt == DCNT_LAST) deb_nxt = s_sync;
      else                   dcnt_nxt = dcnt + 1'b1;
    end
  end

  // Hold is loaded on the same edge deb falls so t never dips between the
  // debounced level and the hold window.
  always_comb begin
    hcnt_nxt = hcnt;
    if (deb && !deb_nxt)  hcnt_nxt = HOLD_LD;
    else if (deb_nxt)     hcnt_nxt = '0;
    else if (hcnt != '0)  hcnt_nxt = hcnt - 1'b1;
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      deb    <= 1'b0;
      deb_q  <= 1'b0;
      dcnt   <= '0;
      hcnt   <= '0;
      cnt    <= '0;
    end else begin
      s_meta <= s;
      s_sync <= s_meta;
      deb    <= deb_nxt;
      deb_q  <= deb;
      dcnt   <= dcnt_nxt;
      hcnt   <= hcnt_nxt;
      if (clr)                    cnt <= '0;
      else if (arr && cnt != '1)  cnt <= cnt + 1'b1;
    end
  end

  assign arr = deb & ~deb_q;
  assign t   = deb | (hcnt != '0);

endmodule

// File: rtl/traffic_sensor.sv
// Detector conditioner for the two-road controller: one independent
// sensor channel per road producing ta/tb, arrival strobes and counts.
module traffic_sensor
  import tlc_pkg::*;
#(
  parameter int unsigned DEB  = DEB_DEF,
  parameter int unsigned HOLD = HOLD_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic          clk,
  input  logic          r_n,
  input  logic          sa,
  input  logic          sb,
  input  logic          clr,
  output logic          ta,
  output logic          tb,
  output logic          arr_a,
  output logic          arr_b,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);

  sensor_channel #(
    .DEB  (DEB),
    .HOLD (HOLD),
    .CW   (CW)
  ) u_chan_a (
    .clk (clk),
    .r_n (r_n),
    .s   (sa),
    .clr (clr),
    .t   (ta),
    .arr (arr_a),
    .cnt (cnt_a)
  );

  sensor_channel #(
    .DEB  (DEB),
    .HOLD (HOLD),
    .CW   (CW)
  ) u_chan_b (
    .clk (clk),
    .r_n (r_n),
    .s   (sb),
    .clr (clr),
    .t   (tb),
    .arr (arr_b),
    .cnt (cnt_b)
  );

endmodule

// File: tb/tb_traffic_sensor.sv
// Self-checking bench for traffic_sensor (DEB=4, HOLD=8, CW=8): timing
// checks inline plus a scoreboard of expected counts per arrival strobe.
module tb_traffic_sensor;

  logic       clk;
  logic       r_n;
  logic       sa;
  logic       sb;
  logic       clr;
  logic       ta;
  logic       tb;
  logic       arr_a;
  logic       arr_b;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] ea, eb;
  logic       pa = 1'b0;
  logic       pb = 1'b0;
  int         ma = 0;
  int         mb = 0;

  traffic_sensor #(
    .DEB  (4),
    .HOLD (8),
    .CW   (8)
  ) dut (
    .clk   (clk),
    .r_n   (r_n),
    .sa    (sa),
    .sb    (sb),
    .clr   (clr),
    .ta    (ta),
    .tb    (tb),
    .arr_a (arr_a),
    .arr_b (arr_b),
    .cnt_a (cnt_a),
    .cnt_b (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: each arr strobe pops the count expected one edge later.
  always @(negedge clk) begin
    if (pa) begin
      check("cnt_a_after_arr", cnt_a, ea);
      pa = 1'b0;
    end
    if (pb) begin
      check("cnt_b_after_arr", cnt_b, eb);
      pb = 1'b0;
    end
    if (arr_a) begin
      if (qa.size() == 0) check("arr_a_spurious", arr_a, 0);
      else begin ea = qa.pop_front(); pa = 1'b1; end
    end
    if (arr_b) begin
      if (qb.size() == 0) check("arr_b_spurious", arr_b, 0);
      else begin eb = qb.pop_front(); pb = 1'b1; end
    end
  end

  task automatic push_a();
    ma = (ma == 255) ? 255 : ma + 1;
    qa.push_back(8'(ma));
  endtask

  task automatic push_b();
    mb = (mb == 255) ? 255 : mb + 1;
    qb.push_back(8'(mb));
  endtask

  initial begin
    r_n = 1'b0; sa = 1'b0; sb = 1'b0; clr = 1'b0;

    // Reset held with activity on every input
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_outputs", {ta, tb, arr_a, arr_b, cnt_a, cnt_b}, 0);
      sa = i[0]; sb = ~i[0]; clr = i[1];
    end
    @(negedge clk);
    sa = 1'b0; sb = 1'b0; clr = 1'b0; r_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clean arrival: ta rises after 2+DEB edges
    sa = 1'b1; push_a();
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check("clean_ta", ta, int'(i >= 6));
      check("clean_arr_a", arr_a, int'(i == 6));
      check("clean_tb", tb, 0);
    end

    // Hold: ta falls 2+DEB+HOLD edges after raw fall
    sa = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("hold_ta", ta, int'(i < 14));
    end

    // Glitch of DEB-1 cycles is rejected
    sa = 1'b1;
    repeat (3) @(negedge clk);
    sa = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("glitch3_ta", ta, 0);
    end

    // Pulse of exactly DEB cycles is accepted
    sa = 1'b1; push_a();
    repeat (4) @(negedge clk);
    sa = 1'b0;
    repeat (4) @(negedge clk);
    check("pulse4_ta_high", ta, 1);
    repeat (30) @(negedge clk);
    check("pulse4_ta_low", ta, 0);

    // Alternating every 2 cycles never settles
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("alt_ta", ta, 0);
      sa = i[1];
    end
    sa = 1'b0;
    repeat (10) @(negedge clk);
    check("alt_cnt_a", cnt_a, 2);

    // Re-arrival 5 cycles after raw fall: ta never drops
    sa = 1'b1; push_a();
    repeat (10) @(negedge clk);
    check("rearr_ta_pre", ta, 1);
    sa = 1'b0;
    repeat (5) @(negedge clk);
    sa = 1'b1; push_a();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rearr_ta", ta, 1);
    end
    sa = 1'b0;
    repeat (30) @(negedge clk);
    check("rearr_ta_end", ta, 0);
    check("rearr_cnt_a", cnt_a, 4);

    // Saturation on road B
    for (int k = 0; k < 260; k++) begin
      sb = 1'b1; push_b();
      repeat (8) @(negedge clk);
      sb = 1'b0;
      repeat (8) @(negedge clk);
    end
    check("sat_cnt_b", cnt_b, 255);
    check("sat_cnt_a_untouched", cnt_a, 4);

    // clr coincident with arr_b wins
    sb = 1'b1;
    mb = 0; qb.push_back(8'd0);
    repeat (6) @(negedge clk);
    check("clr_arr_b_now", arr_b, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_cnt_b", cnt_b, 0);
    check("clr_cnt_a", cnt_a, 0);

    // Async reset while tb is holding
    sb = 1'b0;
    repeat (8) @(negedge clk);
    check("midhold_tb", tb, 1);
    #3 r_n = 1'b0;
    #1 check("async_rst_tb", tb, 0);
    check("async_rst_cnt_b", cnt_b, 0);
    @(negedge clk);
    r_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_tb", tb, 0);
    end

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
